// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Bundle of handshake and bus signals around the
//               instruction-fetch stage. It covers the redirect/stall
//               controls, the instruction-cache lookup and fill ports, the
//               memory refill port, and the IF/ID outputs.
//               modport master : the fetch unit itself
//               modport slave  : the surrounding pipeline, cache and memory
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if;
  // Pipeline control
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  // Instruction cache
  logic [31:0] icache_addr;
  logic        icache_hit;
  logic [31:0] icache_data;
  logic        icache_fill;
  logic [31:0] icache_fill_addr;
  logic [31:0] icache_fill_data;
  // Instruction memory
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  // IF/ID register
  logic [31:0] ins_out;
  logic        hit_out;
  logic [31:0] next_pc_out;

  modport master (
    input  stall, branch_taken, branch_target,
    input  icache_hit, icache_data,
    output icache_addr, icache_fill, icache_fill_addr, icache_fill_data,
    input  mem_ready, mem_data,
    output mem_req, mem_addr,
    output ins_out, hit_out, next_pc_out
  );

  modport slave (
    output stall, branch_taken, branch_target,
    output icache_hit, icache_data,
    input  icache_addr, icache_fill, icache_fill_addr, icache_fill_data,
    output mem_ready, mem_data,
    input  mem_req, mem_addr,
    input  ins_out, hit_out, next_pc_out
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : IF stage. Presents the PC to the instruction cache. On a hit
//               it passes the word and PC+4 to IF/ID and advances. On a miss
//               it performs a single-word refill from memory, writes the
//               word into the cache and retries. It also applies stalls and
//               branch redirects.
// Ports       : clk  - clock, all state updates on rising edge
//               rst  - asynchronous active-high reset
//               bus  - instruction_fetch_unit_if.master (control, cache,
//                      memory and IF/ID signals)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  instruction_fetch_unit_if.master      bus
);

  localparam logic [1:0] c_FETCH    = 2'd0;
  localparam logic [1:0] c_MISS_REQ = 2'd1;
  localparam logic [1:0] c_REFILL   = 2'd2;

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_miss_pc;
  logic [31:0] r_fill_data;
  logic        r_redirect_pend;
  logic [31:0] r_redirect_pc;

  logic [31:0] w_target;
  logic        w_hit;

  assign w_target = bus.branch_target & c_ALIGN_MASK;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_FETCH: begin
        // A redirect or stall suppresses miss handling for the current PC.
        if (!bus.branch_taken && !bus.stall && !bus.icache_hit) begin
          w_state_nxt = c_MISS_REQ;
        end
      end
      c_MISS_REQ: begin
        if (bus.mem_ready) begin
          w_state_nxt = c_REFILL;
        end
      end
      c_REFILL: w_state_nxt = c_FETCH;
      default:  w_state_nxt = c_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    w_hit                = (r_state == c_FETCH) && bus.icache_hit && !rst;
    bus.hit_out          = w_hit;
    bus.ins_out          = w_hit ? bus.icache_data : NOP_INSN;
    bus.icache_addr      = r_pc;
    bus.next_pc_out      = r_pc + 32'd4;
    bus.mem_req          = (r_state == c_MISS_REQ) && !rst;
    bus.mem_addr         = r_miss_pc;
    bus.icache_fill      = (r_state == c_REFILL) && !rst;
    bus.icache_fill_addr = r_miss_pc;
    bus.icache_fill_data = r_fill_data;
  end

  // PC, miss and redirect bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc            <= RESET_PC;
      r_miss_pc       <= 32'd0;
      r_fill_data     <= 32'd0;
      r_redirect_pend <= 1'b0;
      r_redirect_pc   <= 32'd0;
    end else begin
      case (r_state)
        c_FETCH: begin
          if (bus.branch_taken) begin
            r_pc <= w_target;
          end else if (bus.stall) begin
            r_pc <= r_pc;
          end else if (bus.icache_hit) begin
            r_pc <= r_pc + 32'd4;
          end else begin
            r_miss_pc <= r_pc;
          end
        end
        c_MISS_REQ: begin
          if (bus.mem_ready) begin
            r_fill_data <= bus.mem_data;
          end
          // The outstanding memory read is never aborted; remember the
          // newest redirect and apply it once the refill finishes.
          if (bus.branch_taken) begin
            r_redirect_pend <= 1'b1;
            r_redirect_pc   <= w_target;
          end
        end
        c_REFILL: begin
          // A redirect arriving in this very cycle is the latest one.
          if (bus.branch_taken) begin
            r_pc <= w_target;
          end else if (r_redirect_pend) begin
            r_pc <= r_redirect_pc;
          end
          r_redirect_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit
//               with RESET_PC = 0x100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSN (32'h0000_0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = 32'd0;
    bus.icache_hit     = 1'b1;
    bus.icache_data    = 32'h1111_1111;
    bus.mem_ready      = 1'b0;
    bus.mem_data       = 32'd0;

    // Reset values (hit_out masked by rst even with icache_hit=1)
    #3;
    chk("rst_addr",  bus.icache_addr, 32'h100);
    chk("rst_npc",   bus.next_pc_out, 32'h104);
    chk("rst_hit",   {31'd0, bus.hit_out}, 32'd0);
    chk("rst_ins",   bus.ins_out, 32'd0);
    chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("rst_fill",  {31'd0, bus.icache_fill}, 32'd0);

    // Sequential hits from 0x100
    tick();
    rst = 1'b0;
    #2;
    chk("hit0_addr", bus.icache_addr, 32'h100);
    chk("hit0_npc",  bus.next_pc_out, 32'h104);
    chk("hit0_hit",  {31'd0, bus.hit_out}, 32'd1);
    chk("hit0_ins",  bus.ins_out, 32'h1111_1111);
    tick(); #2;
    chk("hit1_addr", bus.icache_addr, 32'h104);
    chk("hit1_npc",  bus.next_pc_out, 32'h108);
    tick(); #2;
    chk("hit2_addr", bus.icache_addr, 32'h108);

    // Branch to 0x40, then stall for two cycles
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    tick();
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b1;
    #2;
    chk("stl0_addr", bus.icache_addr, 32'h40);
    tick(); #2;
    chk("stl1_addr", bus.icache_addr, 32'h40);
    tick();
    bus.stall = 1'b0;
    #2;
    chk("stl2_addr", bus.icache_addr, 32'h40);
    tick(); #2;
    chk("stl_adv",   bus.icache_addr, 32'h44);

    // Miss at 0x200, ready on the third request cycle
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    tick();
    bus.branch_taken = 1'b0;
    bus.icache_hit   = 1'b0;
    #2;
    chk("m_addr",    bus.icache_addr, 32'h200);
    chk("m_nop",     bus.ins_out, 32'd0);
    chk("m_req0",    {31'd0, bus.mem_req}, 32'd0);
    tick();
    bus.icache_hit = 1'b1;   // hit_out must still stay low outside FETCH
    #2;
    chk("m_req1",    {31'd0, bus.mem_req}, 32'd1);
    chk("m_maddr",   bus.mem_addr, 32'h200);
    chk("m_hit1",    {31'd0, bus.hit_out}, 32'd0);
    chk("m_ins1",    bus.ins_out, 32'd0);
    tick(); #2;
    chk("m_req2",    {31'd0, bus.mem_req}, 32'd1);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_data  = 32'hDEAD_BEEF;
    #2;
    chk("m_req3",    {31'd0, bus.mem_req}, 32'd1);
    chk("m_fill3",   {31'd0, bus.icache_fill}, 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_data  = 32'h0;
    #2;
    chk("rf_fill",   {31'd0, bus.icache_fill}, 32'd1);
    chk("rf_faddr",  bus.icache_fill_addr, 32'h200);
    chk("rf_fdata",  bus.icache_fill_data, 32'hDEAD_BEEF);
    chk("rf_req",    {31'd0, bus.mem_req}, 32'd0);
    chk("rf_hit",    {31'd0, bus.hit_out}, 32'd0);
    tick(); #2;
    chk("af_fill",   {31'd0, bus.icache_fill}, 32'd0);
    chk("af_addr",   bus.icache_addr, 32'h200);
    chk("af_hit",    {31'd0, bus.hit_out}, 32'd1);
    tick(); #2;
    chk("af_adv",    bus.icache_addr, 32'h204);

    // Branch has priority over stall and miss; target is word-aligned
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h1003;
    bus.stall         = 1'b1;
    bus.icache_hit    = 1'b0;
    tick();
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    bus.icache_hit   = 1'b1;
    #2;
    chk("br_addr",   bus.icache_addr, 32'h1000);
    chk("br_req",    {31'd0, bus.mem_req}, 32'd0);

    // Redirect to 0x800 during the miss on 0x300
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h300;
    tick();
    bus.branch_taken = 1'b0;
    bus.icache_hit   = 1'b0;
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h800;
    #2;
    chk("rd_req",    {31'd0, bus.mem_req}, 32'd1);
    chk("rd_maddr",  bus.mem_addr, 32'h300);
    tick();
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b1;
    bus.mem_data     = 32'hCAFE_F00D;
    #2;
    chk("rd_maddr2", bus.mem_addr, 32'h300);
    chk("rd_pc",     bus.icache_addr, 32'h300);
    tick();
    bus.mem_ready = 1'b0;
    #2;
    chk("rd_fill",   {31'd0, bus.icache_fill}, 32'd1);
    chk("rd_faddr",  bus.icache_fill_addr, 32'h300);
    chk("rd_fdata",  bus.icache_fill_data, 32'hCAFE_F00D);
    tick();
    bus.icache_hit = 1'b1;
    #2;
    chk("rd_newpc",  bus.icache_addr, 32'h800);
    chk("rd_req2",   {31'd0, bus.mem_req}, 32'd0);
    chk("rd_fill2",  {31'd0, bus.icache_fill}, 32'd0);

    // Asynchronous reset in the middle of a miss
    bus.icache_hit = 1'b0;
    tick(); #2;
    chk("ar_req",    {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_req0",   {31'd0, bus.mem_req}, 32'd0);
    chk("ar_fill0",  {31'd0, bus.icache_fill}, 32'd0);
    chk("ar_addr",   bus.icache_addr, 32'h100);
    bus.mem_ready = 1'b1;
    tick();
    rst            = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.icache_hit = 1'b1;
    #2;
    chk("ar_hit",    {31'd0, bus.hit_out}, 32'd1);
    chk("ar_fill",   {31'd0, bus.icache_fill}, 32'd0);
    tick(); #2;
    chk("ar_adv",    bus.icache_addr, 32'h104);
    chk("ar_fill2",  {31'd0, bus.icache_fill}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
